sram_like_data_responder: RTL



---
 rtl/sram_like_data_responder_if.sv | 37 +++
 rtl/sram_like_data_responder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/sram_like_data_responder_if.sv
// SRAM-like data bus between a CPU pipeline (master) and a memory responder (slave).
// Request side: req/wr/size/wstrb/addr/wdata; response side: addr_ok/data_ok/rdata.
interface sram_like_data_responder_if;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_req,
      output data_sram_wr,
      output data_sram_size,
      output data_sram_wstrb,
      output data_sram_addr,
      output data_sram_wdata,
      input  data_sram_addr_ok,
      input  data_sram_data_ok,
      input  data_sram_rdata
   );

   modport slave (
      input  data_sram_req,
      input  data_sram_wr,
      input  data_sram_size,
      input  data_sram_wstrb,
      input  data_sram_addr,
      input  data_sram_wdata,
      output data_sram_addr_ok,
      output data_sram_data_ok,
      output data_sram_rdata
   );
endinterface

// File: rtl/sram_like_data_responder.sv
// Responder end of the SRAM-like data bus: internal word RAM, byte-strobed
// writes, in-order responses after a fixed latency, at most MAX_OUTSTANDING
// accepted requests awaiting data_ok.
// Optional macro SRAM_RESP_RANDOM_DELAY_EN: an LFSR adds 0..3 cycles to each
// response and occasionally withholds addr_ok; ordering and data are unchanged.
module sram_like_data_responder #(
   parameter int unsigned ADDR_W          = 10,
   parameter int unsigned LATENCY         = 2,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   sram_like_data_responder_if.slave   bus
);
   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned CD_W  = 4;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [CD_W-1:0]  CD_BASE  = CD_W'(LATENCY - 1);

   // word RAM, not reset
   logic [31:0] mem [DEPTH];

   // response queue
   logic              q_wr   [MAX_OUTSTANDING];
   logic [31:0]       q_data [MAX_OUTSTANDING];
   logic [CD_W-1:0]   q_cd   [MAX_OUTSTANDING];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;

   logic              addr_ok;
   logic              accept;
   logic              data_ok;
   logic [31:0]       rdata;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       rd_word;
   logic [CD_W-1:0]   cd_init;

   // size is informational and only part of addr indexes the RAM
   logic unused_bits;
   assign unused_bits = &{1'b0, bus.data_sram_size, bus.data_sram_addr};

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

`ifdef SRAM_RESP_RANDOM_DELAY_EN
   logic [15:0] lfsr;

   // Fibonacci LFSR, taps 16,14,13,11, free-running
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr <= 16'hACE1;
      else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign cd_init = CD_BASE + CD_W'(lfsr[1:0]);

   // accept while a slot is free and the LFSR does not stall this cycle
   always_comb begin
      addr_ok = !reset && (count < CNT_MAX) && (lfsr[3:2] != 2'b11);
   end
`else
   assign cd_init = CD_BASE;

   // accept while a slot is free; a retire this cycle does not free one early
   always_comb begin
      addr_ok = !reset && (count < CNT_MAX);
   end
`endif

   assign idx     = bus.data_sram_addr[ADDR_W+1:2];
   assign accept  = bus.data_sram_req && addr_ok;
   assign rd_word = mem[idx];

   // head responds once its countdown has run out
   always_comb begin
      data_ok = 1'b0;
      rdata   = '0;
      if (count != '0 && q_cd[head] == '0) begin
         data_ok = 1'b1;
         rdata   = q_wr[head] ? 32'h0 : q_data[head];
      end
   end

   assign bus.data_sram_addr_ok = addr_ok;
   assign bus.data_sram_data_ok = data_ok;
   assign bus.data_sram_rdata   = rdata;

   // byte-strobed RAM write at the accept edge
   always_ff @(posedge clk) begin
      if (accept && bus.data_sram_wr) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (bus.data_sram_wstrb[i]) mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
         end
      end
   end

   // queue push/pop, countdowns and outstanding count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            q_wr[i]   <= 1'b0;
            q_data[i] <= '0;
            q_cd[i]   <= '0;
         end
      end else begin
         // younger entries that reach zero early hold there until they are head
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            if (q_cd[i] != '0) q_cd[i] <= q_cd[i] - 1'b1;
         end
         if (accept) begin
            q_wr[tail]   <= bus.data_sram_wr;
            q_data[tail] <= bus.data_sram_wr ? 32'h0 : rd_word;
            q_cd[tail]   <= cd_init;
            tail         <= next_ptr(tail);
         end
         if (data_ok) head <= next_ptr(head);
         case ({accept, data_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule
